des_block_serializer: RTL and testbench
=======================================

DES_BLOCK_SERIALIZER -- requirements
Module: des_block_serializer

Interface
REQ-001 Parameter DEPTH_BLOCKS, default 4, number of 64-bit block slots in the buffer; power of two, 2..64.
REQ-002 clk1  input  1  sole clock; all logic on its rising edge.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 blk_valid  input  1  producer (DES engine) offers a 64-bit result block.
REQ-005 blk_data  input  64  result block; bits [15:0] are word 0, [63:48] are word 3.
REQ-006 blk_ready  output  1  buffer can accept a block this cycle.
REQ-007 rd_en  input  1  consumer strobe taking one 16-bit word (PipeOut read style).
REQ-008 rd_data  output  16  current head word (first-word-fall-through).
REQ-009 rd_valid  output  1  rd_data holds a valid word.
REQ-010 words_avail  output  log2(DEPTH_BLOCKS)+3  count of unread 16-bit words.
REQ-011 underrun  output  1  sticky flag: rd_en seen while rd_valid low.
REQ-012 blk_done  output  1  one-cycle pulse when the last word of a block is read.

Function
REQ-013 A block SHALL be accepted on any clk1 edge with blk_valid=1 and blk_ready=1; no other edge writes the buffer.
REQ-014 blk_ready SHALL be 1 exactly when fewer than DEPTH_BLOCKS blocks are wholly or partly unread, registered from the current occupancy (no same-cycle pass-through of a freed slot).
REQ-015 Words SHALL be emitted in order word 0, 1, 2, 3 of each block; blocks in acceptance order.
REQ-016 Latency: a block accepted on edge N into an empty buffer SHALL present word 0 on rd_data with rd_valid=1 after edge N+1.
REQ-017 rd_data and rd_valid SHALL be registered outputs; rd_en with rd_valid=1 on edge N advances rd_data to the next word after edge N, enabling one word per cycle sustained.
REQ-018 Read pointer SHALL be word-granular (block index + 2-bit word index); the block slot SHALL be freed on the edge that consumes word 3.
REQ-019 blk_done SHALL be 1 for exactly the cycle after the edge consuming word 3.
REQ-020 words_avail SHALL equal 4 x unread-block count minus words consumed from the head block, updated every edge; simultaneous accept and read changes it by +3.
REQ-021 rd_en with rd_valid=0 SHALL be ignored for data, leave pointers unchanged, and set underrun; underrun clears only on reset.
REQ-022 When empty, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-023 Block write and block index pointers SHALL wrap modulo DEPTH_BLOCKS without loss; full and empty distinguished by an extra pointer bit.
REQ-024 blk_valid while blk_ready=0 SHALL not alter state; the producer holds the block.

Reset
REQ-025 reset=1 on an edge SHALL flush the buffer: pointers 0, rd_valid 0, rd_data 16'h0000, words_avail 0, underrun 0, blk_done 0, blk_ready 1 after that edge.
REQ-026 reset SHALL take priority over blk_valid and rd_en on the same edge; a block or word partially read when reset is asserted is discarded.
REQ-027 Buffer storage contents need not be cleared by reset.

Configuration
REQ-028 Macro DES_SER_BYTESWAP_EN: when defined, each emitted word SHALL have its two bytes swapped (rd_data = {w[7:0], w[15:8]}); when undefined, words pass unmodified; ordering, timing and counters identical in both builds.

Verification
REQ-029 Reset, push 64'h0123_4567_89AB_CDEF, rd_en held 1 -> rd_data CDEF, 89AB, 4567, 0123 on consecutive cycles, blk_done pulse after the 4th, then rd_valid 0.
REQ-030 DEPTH_BLOCKS=4, push 4 blocks, no reads -> blk_ready 0, words_avail 16; 5th blk_valid ignored; read 4 words -> blk_ready 1 next cycle.
REQ-031 Full buffer, blk_valid=1 and rd_en consuming word 3 on same edge -> block not accepted that edge, accepted next edge, words_avail 12 then 15.
REQ-032 Empty buffer, rd_en=1 -> underrun 1 and stays 1, rd_data unchanged, words_avail 0; reset -> underrun 0.
REQ-033 Push 10 blocks with random rd_en throttling (DEPTH 4) -> all 40 words emitted in order, pointers wrap, no duplicate or lost word.
REQ-034 Reset asserted after 2 of 4 words read, then push 64'h1111_2222_3333_4444 -> rd_data 4444 first, words_avail 4; with DES_SER_BYTESWAP_EN defined, first word 4444 and 29 rerun with CDEF emitted as EFCD.

Source files
------------

// File: rtl/des_block_serializer_if.sv
// Handshake bundle between the DES engine (block producer), the serializer and the word consumer.
interface des_block_serializer_if #(
  parameter int unsigned DEPTH_BLOCKS = 4
);
  logic                              blk_valid;
  logic [63:0]                       blk_data;
  logic                              blk_ready;
  logic                              rd_en;
  logic [15:0]                       rd_data;
  logic                              rd_valid;
  logic [$clog2(DEPTH_BLOCKS)+2:0]   words_avail;
  logic                              underrun;
  logic                              blk_done;

  modport master (
    output blk_valid, blk_data, rd_en,
    input  blk_ready, rd_data, rd_valid, words_avail, underrun, blk_done
  );

  modport slave (
    input  blk_valid, blk_data, rd_en,
    output blk_ready, rd_data, rd_valid, words_avail, underrun, blk_done
  );
endinterface

// File: rtl/des_block_serializer.sv
// Buffers 64-bit DES result blocks and emits them as 16-bit FWFT words, word 0 first.
// Optional DES_SER_BYTESWAP_EN: swap the two bytes of every emitted word.
module des_block_serializer #(
  parameter int unsigned DEPTH_BLOCKS = 4
) (
  input  logic                   clk1,
  input  logic                   reset,
  des_block_serializer_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH_BLOCKS);
  localparam int unsigned CW = AW + 3;
  localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH_BLOCKS);
  localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

  logic [63:0] mem [DEPTH_BLOCKS];

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_blk;
  logic [AW:0]   rd_blk_nx;
  logic [1:0]    rd_word;
  logic [1:0]    rd_word_nx;
  logic [AW:0]   occ;
  logic [AW:0]   occ_nx;
  logic [15:0]   rd_data_q;
  logic          rd_valid_q;
  logic          underrun_q;
  logic          blk_done_q;
  logic          accept;
  logic          consume;
  logic          last_word;
  logic [63:0]   head_blk;
  logic [15:0]   head_word;
  logic [15:0]   out_word;

  assign occ       = wr_ptr - rd_blk;
  assign accept    = bus.blk_valid && bus.blk_ready && !reset;
  assign consume   = bus.rd_en && rd_valid_q;
  assign last_word = (rd_word == 2'd3);

  // rd_data always mirrors the word at the read pointer; the lookahead pointer
  // reloads it on the same edge that retires the current word.
  always_comb begin
    rd_blk_nx  = rd_blk;
    rd_word_nx = rd_word;
    if (consume) begin
      rd_word_nx = rd_word + 2'd1;
      if (last_word) rd_blk_nx = rd_blk + PTR_ONE;
    end
  end

  assign occ_nx    = wr_ptr - rd_blk_nx;
  assign head_blk  = mem[rd_blk_nx[AW-1:0]];
  assign head_word = head_blk[{rd_word_nx, 4'b0000} +: 16];

`ifdef DES_SER_BYTESWAP_EN
  assign out_word = {head_word[7:0], head_word[15:8]};
`else
  assign out_word = head_word;
`endif

  always_ff @(posedge clk1) begin
    if (accept) mem[wr_ptr[AW-1:0]] <= bus.blk_data;
  end

  always_ff @(posedge clk1) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_blk     <= '0;
      rd_word    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      underrun_q <= 1'b0;
      blk_done_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PTR_ONE;
      rd_blk     <= rd_blk_nx;
      rd_word    <= rd_word_nx;
      blk_done_q <= consume && last_word;
      if (bus.rd_en && !rd_valid_q) underrun_q <= 1'b1;
      // Occupancy before this edge's accept keeps the one-cycle fill latency
      // and guarantees the slot read was written on an earlier edge.
      if (occ_nx != '0) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= out_word;
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.blk_ready   = (occ != FULL_OCC);
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.underrun    = underrun_q;
  assign bus.blk_done    = blk_done_q;
  assign bus.words_avail = {occ, 2'b00} - {{(CW-2){1'b0}}, rd_word};
endmodule

// File: tb/tb_des_block_serializer.sv
// Directed scoreboard bench for des_block_serializer (DEPTH_BLOCKS = 4).
module tb_des_block_serializer;
  localparam int unsigned DEPTH = 4;

  logic clk1 = 1'b0;
  logic reset;
  always #5 clk1 = ~clk1;

  des_block_serializer_if #(.DEPTH_BLOCKS(DEPTH)) bus ();

  des_block_serializer #(.DEPTH_BLOCKS(DEPTH)) dut (
    .clk1  (clk1),
    .reset (reset),
    .bus   (bus.slave)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned rd_count = 0;
  logic [15:0] sb [$];

  function automatic logic [15:0] exp_word(input logic [15:0] w);
`ifdef DES_SER_BYTESWAP_EN
    return {w[7:0], w[15:8]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] d);
    for (int i = 0; i < 4; i++) sb.push_back(exp_word(d[i*16 +: 16]));
  endtask

  // Scores the word taken on the coming edge, then advances one cycle.
  task automatic step();
    logic [15:0] e;
    if (!reset && bus.rd_valid && bus.rd_en) begin
      e = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
      check("rd_word", 32'(bus.rd_data), 32'(e));
      rd_count++;
    end
    @(posedge clk1);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    bit done = 0;
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      if (bus.blk_ready) begin
        sb_push(d);
        done = 1;
      end
      step();
    end
    bus.blk_valid = 1'b0;
    check("push_accepted", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      bus.rd_en = bus.rd_valid;
      step();
    end
    bus.rd_en = 1'b0;
    check("drain_empty", sb.size(), 32'd0);
  endtask

  initial begin
    logic [15:0] held;
    int unsigned nblk;
    reset = 1'b1;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.rd_en     = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'h0000);
    check("rst_words", 32'(bus.words_avail), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_blk_done", 32'(bus.blk_done), 32'd0);
    check("rst_blk_ready", 32'(bus.blk_ready), 32'd1);

    // Single block, streamed out back to back.
    push(64'h0123_4567_89AB_CDEF);
    check("lat_words", 32'(bus.words_avail), 32'd4);
    check("lat_not_yet", 32'(bus.rd_valid), 32'd0);
    step();
    check("lat_valid", 32'(bus.rd_valid), 32'd1);
    check("lat_word0", 32'(bus.rd_data), 32'(exp_word(16'hCDEF)));
    bus.rd_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 32'(bus.rd_valid), 32'd1);
      check("stream_done_low", 32'(bus.blk_done), 32'd0);
      step();
    end
    bus.rd_en = 1'b0;
    check("done_pulse", 32'(bus.blk_done), 32'd1);
    check("empty_valid", 32'(bus.rd_valid), 32'd0);
    step();
    check("done_one_cycle", 32'(bus.blk_done), 32'd0);
    check("no_underrun", 32'(bus.underrun), 32'd0);

    // Fill to capacity, then the full-boundary accept/consume race.
    push(64'hA003_A002_A001_A000);
    push(64'hB003_B002_B001_B000);
    push(64'hC003_C002_C001_C000);
    push(64'hD003_D002_D001_D000);
    check("full_ready", 32'(bus.blk_ready), 32'd0);
    check("full_words", 32'(bus.words_avail), 32'd16);
    bus.blk_valid = 1'b1;
    bus.blk_data  = 64'hE003_E002_E001_E000;
    step();
    step();
    step();
    check("full_ignore", 32'(bus.words_avail), 32'd16);
    bus.rd_en = 1'b1;
    step();
    step();
    step();
    check("part_words", 32'(bus.words_avail), 32'd13);
    check("part_ready", 32'(bus.blk_ready), 32'd0);
    step();
    check("free_words", 32'(bus.words_avail), 32'd12);
    check("free_ready", 32'(bus.blk_ready), 32'd1);
    check("free_done", 32'(bus.blk_done), 32'd1);
    sb_push(64'hE003_E002_E001_E000);
    step();
    bus.blk_valid = 1'b0;
    check("acc_rd_words", 32'(bus.words_avail), 32'd15);
    drain();
    step();
    check("drain_words", 32'(bus.words_avail), 32'd0);
    check("drain_underrun", 32'(bus.underrun), 32'd0);

    // Ten blocks with random consumer throttling; pointers wrap twice.
    rd_count = 0;
    nblk = 0;
    for (int c = 0; c < 600 && (nblk < 10 || sb.size() != 0); c++) begin
      bus.blk_valid = (nblk < 10);
      bus.blk_data  = {$urandom(), $urandom()};
      bus.rd_en     = bus.rd_valid && ($urandom_range(0, 2) != 0);
      if (bus.blk_valid && bus.blk_ready) begin
        sb_push(bus.blk_data);
        nblk++;
      end
      step();
    end
    bus.blk_valid = 1'b0;
    bus.rd_en     = 1'b0;
    check("rand_blocks", nblk, 32'd10);
    check("rand_words", rd_count, 32'd40);
    check("rand_sb_empty", sb.size(), 32'd0);

    // Read strobe on an empty buffer.
    step();
    held = bus.rd_data;
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    step();
    step();
    check("ur_flag", 32'(bus.underrun), 32'd1);
    check("ur_hold_data", 32'(bus.rd_data), 32'(held));
    check("ur_words", 32'(bus.words_avail), 32'd0);
    check("ur_valid", 32'(bus.rd_valid), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ur_cleared", 32'(bus.underrun), 32'd0);

    // Reset in the middle of a block discards it.
    push(64'h9999_8888_7777_6666);
    step();
    bus.rd_en = 1'b1;
    step();
    step();
    bus.rd_en = 1'b0;
    reset = 1'b1;
    bus.rd_en = 1'b1;
    step();
    reset = 1'b0;
    bus.rd_en = 1'b0;
    sb.delete();
    check("mid_rst_words", 32'(bus.words_avail), 32'd0);
    check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    check("mid_rst_data", 32'(bus.rd_data), 32'h0000);
    push(64'h1111_2222_3333_4444);
    check("post_rst_words", 32'(bus.words_avail), 32'd4);
    step();
    check("post_rst_word0", 32'(bus.rd_data), 32'(exp_word(16'h4444)));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
